cprv_hazard_scoreboard: RTL and testbench
=========================================

Name: cprv_hazard_scoreboard

Overview:
Parametrised successor to the single-cycle load-use staller at the EX stage. A per-register pending scoreboard tracks every in-flight long-latency write: loads of variable memory latency, and M-extension mul/div. It gates the EX valid/ready handshake on RAW and WAW hazards and bounds the number of outstanding long ops. Writebacks from NUM_WB independent return ports clear the pending bits.

Parameters:
NREGS, 32, architectural integer registers; x0 is never pending
REG_AW, $clog2(NREGS), register address width
NUM_WB, 2, writeback return ports (port 0 = LSU, port 1 = mul/div)
MAX_OUTSTANDING, 4, cap on in-flight long ops; 1..15
CNT_W, $clog2(MAX_OUTSTANDING+1), occupancy counter width

Ports:
clk  in  1  clock
rst  in  1  reset
valid_ex  in  1  EX holds an instruction
ready_ex  in  1  downstream ready
opcode_ex  in  7  EX opcode
funct7_ex  in  7  EX funct7
rs1_addr_ex  in  REG_AW  source 1
rs2_addr_ex  in  REG_AW  source 2
rd_addr_ex  in  REG_AW  destination
wb_valid  in  NUM_WB  writeback strobe per port
wb_rd_addr  in  NUM_WB*REG_AW  packed writeback rd, port i at [i*REG_AW +: REG_AW]
valid_ex_o  out  1  gated valid
ready_ex_o  out  1  gated ready
stall_o  out  1  hazard stall active
pending_o  out  NREGS  scoreboard bits
outstanding_o  out  CNT_W  in-flight long-op count

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. On reset: pending_o=0, outstanding_o=0. The outputs are combinational, so stall_o=0, valid_ex_o=valid_ex and ready_ex_o=ready_ex during reset.
- Long op: opcode LOAD (0000011), or OP/OP_32 (0110011/0111011) with funct7=0000001. rd=0 is never long and never sets any state.
- Source use: rs1 is used by every opcode except LUI, AUIPC and JAL. rs2 is used only by OP, OP_32, STORE and BRANCH. Index 0 never hazards.
- RAW hazard: a used source has its pending bit set.
- WAW hazard: rd!=0 and pending[rd] is set.
- Capacity hazard: the EX op is long and outstanding_o==MAX_OUTSTANDING.
- stall_o = valid_ex & (RAW | WAW | capacity).
- When stall_o is 1, valid_ex_o=0 and ready_ex_o=0. Otherwise both pass through unchanged. All of this is combinational, zero latency.
- Issue = valid_ex_o & ready_ex. A long issue sets pending[rd] at the next edge and increments the counter.
- Writeback: wb_valid[i] clears pending[wb_rd_addr_i] at the next edge and decrements the counter by 1. The counter decrement equals the number of asserted ports. A writeback to rd=0 still decrements.
- Same-cycle set and clear of the same register: the set wins, and the bit remains 1.
- Counter update: next = count + issue_long - popcount(wb_valid). Simultaneous inc/dec leaves it unchanged.
- Counter at 0 with a writeback is a protocol error; the counter saturates at 0.
- Two ports writing the same rd in one cycle: the bit is cleared and the counter decrements by 2.
- Reset mid-flight: all state clears immediately. Writebacks returning after reset are ignored by the bitmap, and the counter stays saturated at 0.
- Stalled instructions are not consumed; EX holds them until the stall clears.

Optional Feature:
CPRV_SCOREBOARD_BYPASS_EN
- Defined: the hazard check uses pending & ~wb_clear_mask for the current cycle, so a consumer issues in the same cycle its producer writes back (forwarding exists). The capacity check uses count minus the same-cycle writebacks.
- Undefined: the check uses registered pending and count only, adding one bubble after each writeback.

Decomposition:
- Package cprv_pkg holds:
  - opcode constants OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH, LUI, AUIPC, JAL;
  - the FUNCT7_MULDIV constant;
  - function is_long_op(opcode, funct7);
  - functions uses_rs1(opcode) and uses_rs2(opcode).
- One sub-module, cprv_wb_decode: converts the NUM_WB writeback ports into an NREGS clear mask plus a popcount.

Test Plan:
- LOAD x5 issues, then add x6,x5,x7 in EX with no writeback → stall_o=1, valid_ex_o=0, pending_o[5]=1. Then wb_valid[0] with rd=5 → add issues the next cycle, or the same cycle with BYPASS_EN.
- Issue load rd=0, then an op reading x0 → no stall, pending_o=0, outstanding_o=0.
- MAX_OUTSTANDING=4: issue loads to x1..x4, then a fifth load to x8 → capacity stall. A writeback on port 1 rd=3 then releases it and outstanding_o stays 4.
- Long issue rd=9 in the same cycle as a writeback rd=9 → pending_o[9]=1 afterwards and the count is unchanged.
- Writebacks on both ports (rd=1, rd=2) with count=2 → count=0 and both bits clear. A mul writing x1 while x1 is pending → WAW stall.
- rst asserted with 3 outstanding ops → next cycle pending_o=0 and outstanding_o=0. A late writeback after reset leaves the counter at 0.

Source files
------------

// File: rtl/cprv_pkg.sv
// -----------------------------------------------------------------------------
// cprv_pkg
// Shared RV64 decode helpers for the EX-stage hazard logic: major opcode
// constants, the M-extension funct7 marker, and small classification
// functions that tell which source registers an opcode reads and whether an
// instruction is a variable-latency ("long") writer.
// -----------------------------------------------------------------------------
package cprv_pkg;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Loads and mul/div return through a writeback port some unknown number
    // of cycles later, so their destination must be tracked as pending.
    function automatic logic is_long_op(input logic [6:0] opcode,
                                        input logic [6:0] funct7);
        return (opcode == LOAD) ||
               (((opcode == OP) || (opcode == OP_32)) && (funct7 == FUNCT7_MULDIV));
    endfunction

    // Only the U-type and JAL formats have no rs1 field.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == LUI) || (opcode == AUIPC) || (opcode == JAL));
    endfunction

    // rs2 is read by R-type, stores and branches; immediate forms reuse those
    // bits as immediate, so they must not raise false hazards.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OP, OP_32, STORE, BRANCH:                     used = 1'b1;
            OP_IMM, OP_IMM_32, LOAD, LUI, AUIPC, JAL:     used = 1'b0;
            default:                                      used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/cprv_wb_decode.sv
// -----------------------------------------------------------------------------
// cprv_wb_decode
// Turns NUM_WB independent writeback return ports into a one-hot-per-port
// clear mask over the register file plus the number of active ports.
//
// Ports:
//   wb_valid    in  NUM_WB         writeback strobe per port
//   wb_rd_addr  in  NUM_WB*REG_AW  packed rd, port i at [i*REG_AW +: REG_AW]
//   clear_mask  out NREGS          registers written back this cycle
//   wb_count    out WBC_W          number of asserted strobes
// -----------------------------------------------------------------------------
module cprv_wb_decode #(
    parameter int NREGS  = 32,
    parameter int REG_AW = $clog2(NREGS),
    parameter int NUM_WB = 2,
    parameter int WBC_W  = $clog2(NUM_WB + 1)
) (
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*REG_AW-1:0] wb_rd_addr,
    output logic [NREGS-1:0]         clear_mask,
    output logic [WBC_W-1:0]         wb_count
);

    // Every strobe counts toward the decrement, even if two ports name the
    // same register or the register is x0; the mask simply ORs together.
    always_comb begin
        clear_mask = '0;
        wb_count   = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i]) begin
                clear_mask[wb_rd_addr[i*REG_AW +: REG_AW]] = 1'b1;
                wb_count = wb_count + WBC_W'(1);
            end
        end
    end

endmodule

// File: rtl/cprv_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// cprv_hazard_scoreboard
// Per-register pending scoreboard for in-flight loads and mul/div. Gates the
// EX valid/ready handshake on RAW, WAW and outstanding-capacity hazards.
//
// Optional feature macro: CPRV_SCOREBOARD_BYPASS_EN
//   defined   - same-cycle writebacks are visible to the hazard check
//   undefined - hazard check sees registered state only (one bubble)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_ex, ready_ex       EX handshake in
//   opcode_ex, funct7_ex     EX decode fields
//   rs1/rs2/rd_addr_ex       EX register addresses
//   wb_valid, wb_rd_addr     writeback return ports (packed rd)
//   valid_ex_o, ready_ex_o   gated handshake out
//   stall_o                  hazard stall
//   pending_o                scoreboard bits
//   outstanding_o            in-flight long-op count
// -----------------------------------------------------------------------------
module cprv_hazard_scoreboard
    import cprv_pkg::*;
#(
    parameter int NREGS           = 32,
    parameter int REG_AW          = $clog2(NREGS),
    parameter int NUM_WB          = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_ex,
    input  logic                     ready_ex,
    input  logic [6:0]               opcode_ex,
    input  logic [6:0]               funct7_ex,
    input  logic [REG_AW-1:0]        rs1_addr_ex,
    input  logic [REG_AW-1:0]        rs2_addr_ex,
    input  logic [REG_AW-1:0]        rd_addr_ex,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*REG_AW-1:0] wb_rd_addr,
    output logic                     valid_ex_o,
    output logic                     ready_ex_o,
    output logic                     stall_o,
    output logic [NREGS-1:0]         pending_o,
    output logic [CNT_W-1:0]         outstanding_o
);

    localparam int WBC_W = $clog2(NUM_WB + 1);
    localparam int SUM_W = ((CNT_W > WBC_W) ? CNT_W : WBC_W) + 1;

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] clear_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] pend_view;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_view;
    logic [CNT_W-1:0] count_next;
    logic [WBC_W-1:0] wb_count;
    logic [SUM_W-1:0] count_ext;
    logic [SUM_W-1:0] wb_ext;
    logic [SUM_W-1:0] count_sum;
    logic             ex_long;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             waw_hit;
    logic             cap_hit;
    logic             issue_long;

    cprv_wb_decode #(
        .NREGS  (NREGS),
        .REG_AW (REG_AW),
        .NUM_WB (NUM_WB),
        .WBC_W  (WBC_W)
    ) u_wb_decode (
        .wb_valid   (wb_valid),
        .wb_rd_addr (wb_rd_addr),
        .clear_mask (clear_mask),
        .wb_count   (wb_count)
    );

    assign count_ext = SUM_W'(count_q);
    assign wb_ext    = SUM_W'(wb_count);

`ifdef CPRV_SCOREBOARD_BYPASS_EN
    // Forwarding lets a consumer use a value in the cycle it returns, so the
    // hazard check looks through this cycle's writebacks.
    assign pend_view  = pending_q & ~clear_mask;
    assign count_view = (wb_ext >= count_ext) ? '0 : CNT_W'(count_ext - wb_ext);
`else
    assign pend_view  = pending_q;
    assign count_view = count_q;
`endif

    // x0 is hardwired, so it never hazards and never becomes a long writer.
    assign ex_long = is_long_op(opcode_ex, funct7_ex) && (rd_addr_ex != '0);
    assign rs1_hit = uses_rs1(opcode_ex) && (rs1_addr_ex != '0) && pend_view[rs1_addr_ex];
    assign rs2_hit = uses_rs2(opcode_ex) && (rs2_addr_ex != '0) && pend_view[rs2_addr_ex];
    assign waw_hit = (rd_addr_ex != '0) && pend_view[rd_addr_ex];
    assign cap_hit = ex_long && (count_view == CNT_W'(MAX_OUTSTANDING));

    // Reset suppresses the stall so the handshake passes straight through
    // while stale pre-reset state is still in the registers.
    assign stall_o    = ~rst & valid_ex & (rs1_hit | rs2_hit | waw_hit | cap_hit);
    assign valid_ex_o = valid_ex & ~stall_o;
    assign ready_ex_o = ready_ex & ~stall_o;
    assign issue_long = valid_ex_o & ready_ex & ex_long;

    // Set mask and saturating counter update; set is ORed after the clear so
    // a same-cycle issue and writeback of one register leaves it pending.
    always_comb begin
        set_mask = '0;
        if (issue_long) begin
            set_mask[rd_addr_ex] = 1'b1;
        end
        count_sum  = count_ext + SUM_W'(issue_long);
        count_next = (count_sum > wb_ext) ? CNT_W'(count_sum - wb_ext) : '0;
    end

    // Scoreboard state; writebacks arriving with the counter at zero are a
    // protocol error and simply saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= (pending_q & ~clear_mask) | set_mask;
            count_q   <= count_next;
        end
    end

    assign pending_o     = pending_q;
    assign outstanding_o = count_q;

endmodule

// File: tb/tb_cprv_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_cprv_hazard_scoreboard
// Directed scenarios plus a randomized run checked against a behavioural
// model of the scoreboard (register bitmask and integer count).
// -----------------------------------------------------------------------------
module tb_cprv_hazard_scoreboard;

    localparam int NREGS = 32;
    localparam int REG_AW = 5;
    localparam int NUM_WB = 2;
    localparam int MAXO = 4;
    localparam int CNT_W = 3;

    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_OPI    = 7'b0010011;
    localparam logic [6:0] T_OP32   = 7'b0111011;
    localparam logic [6:0] T_OPI32  = 7'b0011011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_SYS    = 7'b1110011;
    localparam logic [6:0] T_MULDIV = 7'b0000001;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     valid_ex;
    logic                     ready_ex;
    logic [6:0]               opcode_ex;
    logic [6:0]               funct7_ex;
    logic [REG_AW-1:0]        rs1_addr_ex;
    logic [REG_AW-1:0]        rs2_addr_ex;
    logic [REG_AW-1:0]        rd_addr_ex;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*REG_AW-1:0] wb_rd_addr;
    logic                     valid_ex_o;
    logic                     ready_ex_o;
    logic                     stall_o;
    logic [NREGS-1:0]         pending_o;
    logic [CNT_W-1:0]         outstanding_o;

    int tests_run = 0;
    int tests_failed = 0;

    cprv_hazard_scoreboard #(
        .NREGS           (NREGS),
        .REG_AW          (REG_AW),
        .NUM_WB          (NUM_WB),
        .MAX_OUTSTANDING (MAXO),
        .CNT_W           (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_ex      (valid_ex),
        .ready_ex      (ready_ex),
        .opcode_ex     (opcode_ex),
        .funct7_ex     (funct7_ex),
        .rs1_addr_ex   (rs1_addr_ex),
        .rs2_addr_ex   (rs2_addr_ex),
        .rd_addr_ex    (rd_addr_ex),
        .wb_valid      (wb_valid),
        .wb_rd_addr    (wb_rd_addr),
        .valid_ex_o    (valid_ex_o),
        .ready_ex_o    (ready_ex_o),
        .stall_o       (stall_o),
        .pending_o     (pending_o),
        .outstanding_o (outstanding_o)
    );

    // 10 ns clock; inputs change 1 ns after the rising edge, outputs are
    // sampled on the falling edge.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic r, input logic [6:0] op,
                          input logic [6:0] f7, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] d);
        valid_ex = v;
        ready_ex = r;
        opcode_ex = op;
        funct7_ex = f7;
        rs1_addr_ex = a1;
        rs2_addr_ex = a2;
        rd_addr_ex = d;
    endtask

    task automatic set_wb(input logic [1:0] v, input logic [4:0] d0, input logic [4:0] d1);
        wb_valid = v;
        wb_rd_addr = {d1, d0};
    endtask

    task automatic idle();
        set_ex(1'b0, 1'b1, T_OP, 7'd0, 5'd0, 5'd0, 5'd0);
        set_wb(2'b00, 5'd0, 5'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset clears state and the handshake passes through during reset.
    task automatic test_reset();
        rst = 1'b1;
        idle();
        set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd1, 5'd2, 5'd5);
        tick();
        tick();
        @(negedge clk);
        tests_run++; if (pending_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pending: got %h expected %h", pending_o, 32'h0); end
        tests_run++; if (outstanding_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", outstanding_o); end
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
        tests_run++; if (valid_ex_o !== 1'b1 || ready_ex_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_passthru: got v=%b r=%b expected v=1 r=1", valid_ex_o, ready_ex_o); end
        tick();
        rst = 1'b0;
        idle();
    endtask

    // Load x5, then add x6,x5,x7 waits for the x5 writeback.
    task automatic test_load_use();
        logic exp_stall;
        set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd1, 5'd0, 5'd5);
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b0 || valid_ex_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL lu_load_issue: got stall=%b v=%b expected stall=0 v=1", stall_o, valid_ex_o); end
        tick();
        set_ex(1'b1, 1'b1, T_OP, 7'd0, 5'd5, 5'd7, 5'd6);
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL lu_raw_stall: got %b expected 1", stall_o); end
        tests_run++; if (valid_ex_o !== 1'b0 || ready_ex_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL lu_gated: got v=%b r=%b expected v=0 r=0", valid_ex_o, ready_ex_o); end
        tests_run++; if (pending_o[5] !== 1'b1 || outstanding_o !== 3'd1) begin tests_failed++; $display("[TB] FAIL lu_pending: got p5=%b cnt=%0d expected p5=1 cnt=1", pending_o[5], outstanding_o); end
        tick();
        set_wb(2'b01, 5'd5, 5'd0);
`ifdef CPRV_SCOREBOARD_BYPASS_EN
        exp_stall = 1'b0;
`else
        exp_stall = 1'b1;
`endif
        @(negedge clk);
        tests_run++; if (stall_o !== exp_stall) begin tests_failed++; $display("[TB] FAIL lu_wb_cycle: got stall=%b expected %b", stall_o, exp_stall); end
        tick();
        set_wb(2'b00, 5'd0, 5'd0);
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b0 || valid_ex_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL lu_release: got stall=%b v=%b expected stall=0 v=1", stall_o, valid_ex_o); end
        tests_run++; if (pending_o !== 32'h0 || outstanding_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL lu_clean: got p=%h cnt=%0d expected p=0 cnt=0", pending_o, outstanding_o); end
        tick();
        idle();
    endtask

    // A load to x0 is not tracked and reading x0 never hazards.
    task automatic test_x0();
        set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL x0_load: got stall=%b expected 0", stall_o); end
        tick();
        set_ex(1'b1, 1'b1, T_OP, 7'd0, 5'd0, 5'd0, 5'd10);
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL x0_read: got stall=%b expected 0", stall_o); end
        tests_run++; if (pending_o !== 32'h0 || outstanding_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL x0_state: got p=%h cnt=%0d expected p=0 cnt=0", pending_o, outstanding_o); end
        tick();
        idle();
    endtask

    // Four loads fill the budget; the fifth waits for a port-1 writeback.
    task automatic test_capacity();
        logic exp_stall;
        for (int r = 1; r <= 4; r++) begin
            set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd0, 5'd0, 5'(r));
            @(negedge clk);
            tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL cap_fill_%0d: got stall=%b expected 0", r, stall_o); end
            tick();
        end
        set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd0, 5'd0, 5'd8);
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b1 || outstanding_o !== 3'd4) begin tests_failed++; $display("[TB] FAIL cap_full: got stall=%b cnt=%0d expected stall=1 cnt=4", stall_o, outstanding_o); end
        tick();
        set_wb(2'b10, 5'd0, 5'd3);
`ifdef CPRV_SCOREBOARD_BYPASS_EN
        exp_stall = 1'b0;
`else
        exp_stall = 1'b1;
`endif
        @(negedge clk);
        tests_run++; if (stall_o !== exp_stall) begin tests_failed++; $display("[TB] FAIL cap_wb_cycle: got stall=%b expected %b", stall_o, exp_stall); end
        tick();
        set_wb(2'b00, 5'd0, 5'd0);
`ifndef CPRV_SCOREBOARD_BYPASS_EN
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b0 || outstanding_o !== 3'd3) begin tests_failed++; $display("[TB] FAIL cap_release: got stall=%b cnt=%0d expected stall=0 cnt=3", stall_o, outstanding_o); end
        tick();
`endif
        idle();
        @(negedge clk);
        tests_run++; if (outstanding_o !== 3'd4 || pending_o !== 32'h0000_0116) begin tests_failed++; $display("[TB] FAIL cap_after: got p=%h cnt=%0d expected p=00000116 cnt=4", pending_o, outstanding_o); end
        do_reset();
    endtask

    // Issuing mul x9 while a writeback to x9 arrives leaves x9 pending.
    task automatic test_set_clear();
        set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd0, 5'd0, 5'd12);
        tick();
        set_ex(1'b1, 1'b1, T_OP, T_MULDIV, 5'd0, 5'd0, 5'd9);
        set_wb(2'b01, 5'd9, 5'd0);
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL sc_issue: got stall=%b expected 0", stall_o); end
        tick();
        idle();
        @(negedge clk);
        tests_run++; if (pending_o !== 32'h0000_1200 || outstanding_o !== 3'd1) begin tests_failed++; $display("[TB] FAIL sc_state: got p=%h cnt=%0d expected p=00001200 cnt=1", pending_o, outstanding_o); end
        do_reset();
    endtask

    // WAW stall, then both ports return together, then both name one rd.
    task automatic test_dual_wb();
        set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd0, 5'd0, 5'd1);
        tick();
        set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd0, 5'd0, 5'd2);
        tick();
        set_ex(1'b1, 1'b1, T_OP, T_MULDIV, 5'd0, 5'd0, 5'd1);
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b1 || outstanding_o !== 3'd2) begin tests_failed++; $display("[TB] FAIL dw_waw: got stall=%b cnt=%0d expected stall=1 cnt=2", stall_o, outstanding_o); end
        tick();
        idle();
        set_wb(2'b11, 5'd1, 5'd2);
        tick();
        set_wb(2'b00, 5'd0, 5'd0);
        @(negedge clk);
        tests_run++; if (pending_o !== 32'h0 || outstanding_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL dw_both: got p=%h cnt=%0d expected p=0 cnt=0", pending_o, outstanding_o); end
        set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd0, 5'd0, 5'd3);
        tick();
        set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd0, 5'd0, 5'd4);
        tick();
        idle();
        set_wb(2'b11, 5'd3, 5'd3);
        tick();
        set_wb(2'b00, 5'd0, 5'd0);
        @(negedge clk);
        tests_run++; if (pending_o !== 32'h0000_0010 || outstanding_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL dw_same_rd: got p=%h cnt=%0d expected p=00000010 cnt=0", pending_o, outstanding_o); end
        do_reset();
    endtask

    // Reset with three loads outstanding, then a stale writeback.
    task automatic test_reset_midflight();
        for (int r = 1; r <= 3; r++) begin
            set_ex(1'b1, 1'b1, T_LOAD, 7'd0, 5'd0, 5'd0, 5'(r));
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (pending_o !== 32'h0 || outstanding_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL rm_cleared: got p=%h cnt=%0d expected p=0 cnt=0", pending_o, outstanding_o); end
        tick();
        set_wb(2'b01, 5'd2, 5'd0);
        tick();
        set_wb(2'b00, 5'd0, 5'd0);
        @(negedge clk);
        tests_run++; if (pending_o !== 32'h0 || outstanding_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL rm_late_wb: got p=%h cnt=%0d expected p=0 cnt=0", pending_o, outstanding_o); end
        tick();
    endtask

    // Random traffic against a model: a 32-bit pending set and an integer
    // count of loads/muls that have issued but not yet returned.
    task automatic test_random();
        logic [6:0]  ops [11];
        logic [31:0] m_pend;
        logic [31:0] view;
        logic [31:0] clr;
        int          m_cnt;
        int          cnt_view;
        int          nwb;
        logic        is_long;
        logic        use1;
        logic        use2;
        logic        hazard;
        logic        e_stall;
        logic        e_valid;
        logic        e_ready;
        logic [4:0]  d0;
        logic [4:0]  d1;
        logic [1:0]  wv;
        ops = '{T_OP, T_OPI, T_OP32, T_OPI32, T_LOAD, T_STORE, T_BRANCH,
                T_LUI, T_AUIPC, T_JAL, T_SYS};
        do_reset();
        m_pend = '0;
        m_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 49) == 0);
            set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   ops[$urandom_range(0, 10)],
                   ($urandom_range(0, 1) == 0) ? T_MULDIV : 7'd0,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)));
            wv = 2'b00;
            wv[0] = ($urandom_range(0, 3) == 0);
            wv[1] = ($urandom_range(0, 3) == 0);
            d0 = 5'($urandom_range(0, 7));
            d1 = 5'($urandom_range(0, 7));
            set_wb(wv, d0, d1);

            clr = '0;
            nwb = 0;
            if (wv[0]) begin clr[d0] = 1'b1; nwb++; end
            if (wv[1]) begin clr[d1] = 1'b1; nwb++; end
            view = m_pend;
            cnt_view = m_cnt;
`ifdef CPRV_SCOREBOARD_BYPASS_EN
            view = m_pend & ~clr;
            cnt_view = (m_cnt > nwb) ? m_cnt - nwb : 0;
`endif
            is_long = (rd_addr_ex != 0) && ((opcode_ex == T_LOAD) ||
                      ((opcode_ex == T_OP || opcode_ex == T_OP32) && funct7_ex == T_MULDIV));
            use1 = !(opcode_ex inside {T_LUI, T_AUIPC, T_JAL});
            use2 = (opcode_ex inside {T_OP, T_OP32, T_STORE, T_BRANCH});
            hazard = (use1 && rs1_addr_ex != 0 && view[rs1_addr_ex]) ||
                     (use2 && rs2_addr_ex != 0 && view[rs2_addr_ex]) ||
                     (rd_addr_ex != 0 && view[rd_addr_ex]) ||
                     (is_long && cnt_view == MAXO);
            e_stall = !rst && valid_ex && hazard;
            e_valid = valid_ex && !e_stall;
            e_ready = ready_ex && !e_stall;

            @(negedge clk);
            tests_run++; if (stall_o !== e_stall) begin tests_failed++; $display("[TB] FAIL rnd_stall cyc %0d: got %b expected %b", cyc, stall_o, e_stall); end
            tests_run++; if (valid_ex_o !== e_valid || ready_ex_o !== e_ready) begin tests_failed++; $display("[TB] FAIL rnd_hs cyc %0d: got v=%b r=%b expected v=%b r=%b", cyc, valid_ex_o, ready_ex_o, e_valid, e_ready); end
            tests_run++; if (pending_o !== m_pend) begin tests_failed++; $display("[TB] FAIL rnd_pending cyc %0d: got %h expected %h", cyc, pending_o, m_pend); end
            tests_run++; if (int'(outstanding_o) != m_cnt) begin tests_failed++; $display("[TB] FAIL rnd_count cyc %0d: got %0d expected %0d", cyc, outstanding_o, m_cnt); end

            if (rst) begin
                m_pend = '0;
                m_cnt = 0;
            end else begin
                m_pend = m_pend & ~clr;
                if (e_valid && ready_ex && is_long) begin
                    m_pend[rd_addr_ex] = 1'b1;
                    m_cnt++;
                end
                m_cnt = m_cnt - nwb;
                if (m_cnt < 0) m_cnt = 0;
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_x0();
        test_capacity();
        test_set_clear();
        test_dual_wb();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
